// File: rtl/instr_issue_queue_if.sv
// ---------------------------------------------------------------------------
// instr_issue_queue_if
// Bundles the host push channel, the controller issue channel and the status
// outputs of the instruction issue queue.
//   in_valid / in_ready / in_instr : host push handshake (instr = {opcode, addr})
//   ctrl_idle                      : controller reports its Start state
//   s_update / instruction         : one-cycle issue strobe and issued word
//   level / busy                   : FIFO occupancy and activity flag
//   illegal / illegal_cnt          : discard pulse and saturating discard count
// Modports: master = host/controller side, slave = the queue.
// ---------------------------------------------------------------------------
interface instr_issue_queue_if #(
    parameter int K     = 8,
    parameter int DEPTH = 8
);
    localparam int IW = 3 + $clog2(K);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic          ctrl_idle;
    logic          s_update;
    logic [IW-1:0] instruction;
    logic [LW-1:0] level;
    logic          busy;
    logic          illegal;
    logic [7:0]    illegal_cnt;

    modport master (
        output in_valid, in_instr, ctrl_idle,
        input  in_ready, s_update, instruction, level, busy, illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, in_instr, ctrl_idle,
        output in_ready, s_update, instruction, level, busy, illegal, illegal_cnt
    );
endinterface

// File: rtl/instr_issue_queue.sv
// ---------------------------------------------------------------------------
// instr_issue_queue
// Instruction front-end for the TPU controller. Host instructions are
// buffered in a DEPTH-entry FIFO and handed to the controller one at a time,
// only while the controller is idle. Opcodes 5..7 are discarded at the head
// of the queue, with a one-cycle pulse and a saturating 8-bit count.
// Ports:
//   clk   : clock, all state on rising edge
//   rst   : asynchronous active-high reset
//   q_if  : instr_issue_queue_if.slave (host push, controller issue, status)
// ---------------------------------------------------------------------------
module instr_issue_queue #(
    parameter int N     = 4,
    parameter int K     = 8,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_issue_queue_if.slave   q_if
);
    localparam int IW = 3 + $clog2(K);
    localparam int AW = $clog2(DEPTH);
    // N has no effect on the queue; this constant-true term only keeps the
    // parameter attached to the logic.
    localparam bit N_VALID = (N > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] instr_q, instr_d;
    logic          supd_q, supd_d;
    logic          ill_q, ill_d;
    logic [7:0]    cnt_q, cnt_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [IW-1:0] head;
    logic          head_illegal;

    // Pointers carry one extra wrap bit: equal index with differing wrap bit
    // means full, identical pointers mean empty.
    always_comb begin
        full         = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        empty        = (wptr_q == rptr_q);
        head         = mem_q[rptr_q[AW-1:0]];
        head_illegal = (head[IW-1 -: 3] > 3'd4);
        push         = q_if.in_valid && !full;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        instr_d = '0;
        supd_d  = 1'b0;
        ill_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (head_illegal) begin
                        // Discard regardless of controller state.
                        pop   = 1'b1;
                        ill_d = 1'b1;
                        if (cnt_q != 8'hFF) begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else if (q_if.ctrl_idle) begin
                        state_d = S_ISSUE;
                        supd_d  = 1'b1;
                        instr_d = head;
                    end
                end
            end
            S_ISSUE: begin
                // The head stays in the FIFO while the strobe is out and
                // leaves on the edge that ends the strobe.
                pop     = 1'b1;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!q_if.ctrl_idle) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (q_if.ctrl_idle) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        wptr_d = push ? (wptr_q + 1'b1) : wptr_q;
        rptr_d = pop  ? (rptr_q + 1'b1) : rptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            instr_q <= '0;
            supd_q  <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            instr_q <= instr_d;
            supd_q  <= supd_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage needs no reset; only pointer-covered entries are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= q_if.in_instr;
        end
    end

    assign q_if.in_ready    = !full;
    assign q_if.level       = wptr_q - rptr_q;
    assign q_if.busy        = N_VALID && ((state_q != S_IDLE) || !empty);
    assign q_if.s_update    = supd_q;
    assign q_if.instruction = instr_q;
    assign q_if.illegal     = ill_q;
    assign q_if.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_instr_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_issue_queue
// Directed bench for instr_issue_queue with a queue-level reference model
// compared against the DUT on every falling edge, plus hand-computed checks.
// ---------------------------------------------------------------------------
module tb_instr_issue_queue;
    localparam int K     = 8;
    localparam int DEPTH = 8;
    localparam int IW    = 3 + $clog2(K);

    logic clk = 1'b0;
    logic rst;

    instr_issue_queue_if #(.K(K), .DEPTH(DEPTH)) bus ();

    instr_issue_queue #(.N(4), .K(K), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .q_if (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [IW-1:0] m_fifo[$];
    bit            m_strobe, m_out, m_seen_busy, m_ill;
    logic [IW-1:0] m_instr;
    int            m_cnt;
    bit            mdl_accept, mdl_strobe, mdl_ill;
    logic [IW-1:0] mdl_instr, mdl_head;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete();
            m_strobe    = 0;
            m_out       = 0;
            m_seen_busy = 0;
            m_ill       = 0;
            m_instr     = '0;
            m_cnt       = 0;
        end else begin
            mdl_accept = bus.in_valid && (m_fifo.size() < DEPTH);
            mdl_strobe = 0;
            mdl_ill    = 0;
            mdl_instr  = '0;
            if (m_strobe) begin
                void'(m_fifo.pop_front());
                m_out       = 1;
                m_seen_busy = 0;
            end else if (m_out) begin
                if (!m_seen_busy) begin
                    if (!bus.ctrl_idle) m_seen_busy = 1;
                end else if (bus.ctrl_idle) begin
                    m_out = 0;
                end
            end else if (m_fifo.size() != 0) begin
                mdl_head = m_fifo[0];
                if (mdl_head[IW-1 -: 3] >= 3'd5) begin
                    void'(m_fifo.pop_front());
                    mdl_ill = 1;
                    if (m_cnt < 255) m_cnt++;
                end else if (bus.ctrl_idle) begin
                    mdl_strobe = 1;
                    mdl_instr  = mdl_head;
                end
            end
            if (mdl_accept) m_fifo.push_back(bus.in_instr);
            m_strobe = mdl_strobe;
            m_ill    = mdl_ill;
            m_instr  = mdl_instr;
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("s_update",    bus.s_update,    m_strobe);
            check("instruction", bus.instruction, m_strobe ? m_instr : '0);
            check("level",       bus.level,       m_fifo.size());
            check("in_ready",    bus.in_ready,    m_fifo.size() < DEPTH);
            check("illegal",     bus.illegal,     m_ill);
            check("illegal_cnt", bus.illegal_cnt, m_cnt);
            check("busy",        bus.busy,        m_strobe || m_out || (m_fifo.size() != 0));
        end
    end

    // Pulse counters sampled just after each rising edge.
    int n_supd = 0;
    int n_ill  = 0;
    always @(posedge clk) begin
        #1;
        if (bus.s_update === 1'b1) n_supd++;
        if (bus.illegal === 1'b1)  n_ill++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [IW-1:0] ins);
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic ack();
        bus.ctrl_idle = 1'b0;
        cyc(2);
        bus.ctrl_idle = 1'b1;
        cyc();
    endtask

    task automatic wait_issue(output logic [IW-1:0] ins);
        bit found = 0;
        ins = '0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (bus.s_update === 1'b1) begin
                found = 1;
                ins   = bus.instruction;
                break;
            end
        end
        check("issue_timeout", found, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [IW-1:0] ins;
        int s0, i0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.ctrl_idle = 1'b0;
        cyc(2);
        check("rst_level",    bus.level, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_s_update", bus.s_update, 0);
        check("rst_busy",     bus.busy, 0);
        check("rst_cnt",      bus.illegal_cnt, 0);
        rst    = 1'b0;
        cmp_en = 1;

        // Reset in the middle of WAIT_ACK with three entries left.
        bus.ctrl_idle = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_instr = {3'd1, 3'(k)};
            cyc();
        end
        bus.in_valid = 1'b0;
        check("t1_level_before", bus.level, 3);
        check("t1_busy_before",  bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t1_level",    bus.level, 0);
        check("t1_s_update", bus.s_update, 0);
        check("t1_in_ready", bus.in_ready, 1);
        check("t1_busy",     bus.busy, 0);
        cyc();
        rst = 1'b0;
        s0 = n_supd;
        cyc(3);
        check("t1_no_issue_after_rst", n_supd - s0, 0);

        // Single issue latency.
        push({3'd1, 3'd5});
        check("t2_level_e0", bus.level, 1);
        check("t2_supd_e0",  bus.s_update, 0);
        cyc();
        check("t2_supd_e1",  bus.s_update, 1);
        check("t2_instr_e1", bus.instruction, 8'h0D);
        bus.ctrl_idle = 1'b0;
        cyc();
        check("t2_supd_e2",  bus.s_update, 0);
        check("t2_level_e2", bus.level, 0);
        cyc();
        bus.ctrl_idle = 1'b1;
        cyc();
        check("t2_busy_end", bus.busy, 0);

        // Handshake hold.
        bus.in_valid = 1'b1;
        bus.in_instr = 6'h11;
        cyc();
        bus.in_instr = 6'h12;
        cyc();
        bus.in_valid = 1'b0;
        check("t3_supd_first",  bus.s_update, 1);
        check("t3_instr_first", bus.instruction, 8'h11);
        bus.ctrl_idle = 1'b0;
        s0 = n_supd;
        cyc(20);
        check("t3_no_second_issue", n_supd - s0, 0);
        bus.ctrl_idle = 1'b1;
        cyc();
        check("t3_supd_rise_plus1", bus.s_update, 0);
        cyc();
        check("t3_supd_rise_plus2", bus.s_update, 1);
        check("t3_instr_second",    bus.instruction, 8'h12);
        ack();

        // Full queue.
        bus.ctrl_idle = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus.in_instr = {3'(k % 5), 3'(k)};
            cyc();
            if (k == 7) begin
                check("t4_level_full",    bus.level, 8);
                check("t4_in_ready_full", bus.in_ready, 0);
            end
        end
        bus.in_valid = 1'b0;
        check("t4_level_after_9th", bus.level, 8);
        check("t4_ready_after_9th", bus.in_ready, 0);
        for (int k = 0; k < 8; k++) begin
            bus.ctrl_idle = 1'b1;
            wait_issue(ins);
            check("t4_order", ins, {3'(k % 5), 3'(k)});
            ack();
        end
        check("t4_level_drained", bus.level, 0);

        // Illegal opcodes.
        bus.ctrl_idle = 1'b0;
        i0 = n_ill;
        s0 = n_supd;
        bus.in_valid = 1'b1;
        bus.in_instr = 6'h31;
        cyc();
        bus.in_instr = 6'h13;
        cyc();
        bus.in_instr = 6'h3C;
        cyc();
        bus.in_valid = 1'b0;
        cyc(3);
        bus.ctrl_idle = 1'b1;
        wait_issue(ins);
        check("t5_issued", ins, 8'h13);
        ack();
        cyc(3);
        check("t5_ill_pulses", n_ill - i0, 2);
        check("t5_issues",     n_supd - s0, 1);
        check("t5_cnt",        bus.illegal_cnt, 2);
        check("t5_level",      bus.level, 0);
        i0 = n_ill;
        bus.in_valid = 1'b1;
        bus.in_instr = {3'd5, 3'd0};
        cyc(300);
        bus.in_valid = 1'b0;
        cyc(3);
        check("t5_cnt_sat",    bus.illegal_cnt, 255);
        check("t5_pulses_300", n_ill - i0, 300);
        check("t5_level_end",  bus.level, 0);

        // Push on the ISSUE exit edge with one entry queued.
        bus.ctrl_idle = 1'b1;
        push({3'd0, 3'd5});
        cyc();
        check("t6_supd", bus.s_update, 1);
        bus.in_valid  = 1'b1;
        bus.in_instr  = {3'd4, 3'd2};
        bus.ctrl_idle = 1'b0;
        cyc();
        bus.in_valid = 1'b0;
        check("t6_level_same", bus.level, 1);
        check("t6_supd_off",   bus.s_update, 0);
        cyc();
        bus.ctrl_idle = 1'b1;
        wait_issue(ins);
        check("t6_second", ins, 8'h22);
        ack();
        check("t6_level_end", bus.level, 0);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
